serial_parity_rx: RTL and testbench

- Serial receiver: the decoding end of the team's XOR parity generator.
- Recovers asynchronous frames: start bit (0), DATA_W data bits LSB-first, one parity bit, stop bit (1).
- Re-computes parity by XOR reduction and checks it against the received parity bit.
- Sits between an external serial pin and a parallel consumer; single clock domain after the input synchronizer.

---
 rtl/serial_parity_rx_pkg.sv | 20 ++
 rtl/rx_sync.sv | 23 ++
 rtl/serial_parity_rx.sv | 121 ++++++++++++
 tb/tb_serial_parity_rx.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/serial_parity_rx_pkg.sv
// Shared definitions for the serial parity receiver (and its generator twin).
// Holds the FSM state encoding, the default bit period, and the parity-mode
// constants so both ends of the link agree on them.
package serial_parity_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5   // stop bit was 0; wait for the line to return high
  } rx_state_e;

  localparam int DEF_CLKS_PER_BIT = 16;

  localparam int PAR_MODE_EVEN = 0;
  localparam int PAR_MODE_ODD  = 1;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Both flops reset to 1 (line idle) so a reset never fakes a start bit.
// Ports: clk, rst_n (async low), d (async input), q (synchronized output).
module rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_parity_rx.sv
// Asynchronous serial frame receiver with parity check.
// Frame: start(0), DATA_W data bits LSB first, parity bit, stop(1).
// Ports:
//   clk, rst_n        - clock, async active-low reset
//   rx_in             - serial line (idle high, asynchronous)
//   data_out          - last received word, updated only when a frame ends
//   data_valid        - 1-cycle pulse at end of frame
//   parity_err        - 1-cycle pulse with data_valid, parity mismatch
//   frame_err         - 1-cycle pulse with data_valid, stop bit was 0
//   busy              - high whenever the FSM is not idle
module serial_parity_rx
  import serial_parity_rx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int PARITY_ODD   = PAR_MODE_EVEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
  localparam logic          ODD_BIT   = PARITY_ODD[0];

  rx_state_e         state, state_nx;
  logic              rx_s;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bit_idx;
  logic [DATA_W-1:0] shift_reg;
  logic              par_acc;
  logic              par_bad;
  logic              tick;

  rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_in),
    .q     (rx_s)
  );

  // Sampling point: half a bit after the start edge, then every full bit.
  assign tick = (state == ST_START) ? (cnt == HALF_LAST) : (cnt == FULL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (!rx_s) state_nx = ST_START;
      ST_START:  if (tick) state_nx = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:   if (tick && bit_idx == BIT_LAST) state_nx = ST_PARITY;
      ST_PARITY: if (tick) state_nx = ST_STOP;
      ST_STOP:   if (tick) state_nx = rx_s ? ST_IDLE : ST_BREAK;
      ST_BREAK:  if (rx_s) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      par_acc    <= 1'b0;
      par_bad    <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;

      // Held at zero while idle/breaking so START always begins from 0.
      if (state == ST_IDLE || state == ST_BREAK || tick) cnt <= '0;
      else                                               cnt <= cnt + 1'b1;

      if (tick) begin
        case (state)
          ST_START: begin
            bit_idx <= '0;
            par_acc <= 1'b0;
          end
          ST_DATA: begin
            // LSB arrives first: shifting in from the top lands it at bit 0.
            shift_reg <= {rx_s, shift_reg[DATA_W-1:1]};
            par_acc   <= par_acc ^ rx_s;
            bit_idx   <= bit_idx + 1'b1;
          end
          ST_PARITY: par_bad <= par_acc ^ rx_s ^ ODD_BIT;
          ST_STOP: begin
            data_out   <= shift_reg;
            data_valid <= 1'b1;
            parity_err <= par_bad;
            frame_err  <= ~rx_s;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_parity_rx.sv
// Directed bench for serial_parity_rx: an even-parity and an odd-parity
// instance share one serial line; a monitor logs every data_valid pulse.
module tb_serial_parity_rx;

  localparam int DW  = 8;
  localparam int CPB = 16;
  // Line drive (negedge) -> 2 sync flops -> IDLE detect edge T0 -> +168.
  localparam int LAT = 2 + 1 + CPB / 2 + (DW + 2) * CPB;
  localparam int FRAME = (DW + 3) * CPB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_in = 1'b1;
  logic [DW-1:0] data_out, o_data_out;
  logic          data_valid, parity_err, frame_err, busy;
  logic          o_data_valid, o_parity_err, o_frame_err, o_busy;

  always #5 clk = ~clk;

  serial_parity_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .data_out(data_out),
    .data_valid(data_valid), .parity_err(parity_err), .frame_err(frame_err),
    .busy(busy)
  );

  serial_parity_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_ODD(1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .data_out(o_data_out),
    .data_valid(o_data_valid), .parity_err(o_parity_err), .frame_err(o_frame_err),
    .busy(o_busy)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          pe;
    logic          fe;
    int            t;
  } rec_t;

  rec_t vq[$];
  int   cyc = 0;
  int   o_n = 0;
  logic o_pe_last = 1'bx;
  logic busy_after = 1'bx;
  int   n_chk = 0;
  int   n_err = 0;

  // Monitor: sample 1 time unit after each rising edge.
  initial begin
    logic prev_dv;
    prev_dv = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (prev_dv) busy_after = busy;
      prev_dv = data_valid;
      if (data_valid) vq.push_back('{d: data_out, pe: parity_err, fe: frame_err, t: cyc});
      if (o_data_valid) begin
        o_n++;
        o_pe_last = o_parity_err;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic rec_t rec_at(input int i);
    rec_t r;
    r = '{d: 'x, pe: 1'bx, fe: 1'bx, t: -1};
    if (i >= 0 && i < vq.size()) r = vq[i];
    return r;
  endfunction

  // All drive tasks start and end on a falling edge.
  task automatic drive_bit(input logic b, input int n);
    rx_in = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic par, input logic stop,
                            output int t_start);
    t_start = cyc;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < DW; i++) drive_bit(d[i], CPB);
    drive_bit(par, CPB);
    drive_bit(stop, CPB);
  endtask

  initial begin
    int   t0, t1;
    int   n0;
    rec_t r, r2;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst data_out", 32'(data_out), 32'h0);
    chk("rst data_valid", 32'(data_valid), 32'h0);
    chk("rst parity_err", 32'(parity_err), 32'h0);
    chk("rst frame_err", 32'(frame_err), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Clean frame 0xA5 (four ones -> even parity bit 0)
    send_frame(8'hA5, 1'b0, 1'b1, t0);
    drive_bit(1'b1, CPB);
    chk("clean count", 32'(vq.size()), 32'd1);
    r = rec_at(0);
    chk("clean data", 32'(r.d), 32'hA5);
    chk("clean perr", 32'(r.pe), 32'h0);
    chk("clean ferr", 32'(r.fe), 32'h0);
    chk("clean latency", 32'(r.t - t0), 32'(LAT));
    chk("clean busy after", 32'(busy_after), 32'h0);
    chk("clean odd perr", 32'(o_pe_last), 32'h1);

    // Parity error: 0x3C has four ones, parity bit 1 is wrong for even mode
    send_frame(8'h3C, 1'b1, 1'b1, t0);
    drive_bit(1'b1, CPB);
    chk("perr count", 32'(vq.size()), 32'd2);
    r = rec_at(1);
    chk("perr data", 32'(r.d), 32'h3C);
    chk("perr perr", 32'(r.pe), 32'h1);
    chk("perr ferr", 32'(r.fe), 32'h0);
    chk("perr odd count", 32'(o_n), 32'd2);
    chk("perr odd perr", 32'(o_pe_last), 32'h0);

    // Glitch: 5 cycles low is rejected at the mid-start sample
    drive_bit(1'b0, 5);
    chk("glitch busy", 32'(busy), 32'h1);
    drive_bit(1'b1, 40);
    chk("glitch count", 32'(vq.size()), 32'd2);
    chk("glitch data held", 32'(data_out), 32'h3C);
    chk("glitch idle", 32'(busy), 32'h0);

    // Framing error then break: 0x0F (even parity 0), stop 0, line held low
    send_frame(8'h0F, 1'b0, 1'b0, t0);
    drive_bit(1'b0, 100);
    chk("ferr count", 32'(vq.size()), 32'd3);
    r = rec_at(2);
    chk("ferr data", 32'(r.d), 32'h0F);
    chk("ferr ferr", 32'(r.fe), 32'h1);
    chk("ferr perr", 32'(r.pe), 32'h0);
    chk("break busy", 32'(busy), 32'h1);
    drive_bit(1'b1, 10);
    chk("break released", 32'(busy), 32'h0);
    drive_bit(1'b1, 200);
    chk("break no phantom", 32'(vq.size()), 32'd3);

    // Back-to-back: 0x01 (parity 1) then 0xFE (parity 1), no idle gap
    send_frame(8'h01, 1'b1, 1'b1, t0);
    send_frame(8'hFE, 1'b1, 1'b1, t1);
    drive_bit(1'b1, CPB);
    chk("b2b count", 32'(vq.size()), 32'd5);
    r  = rec_at(3);
    r2 = rec_at(4);
    chk("b2b data0", 32'(r.d), 32'h01);
    chk("b2b data1", 32'(r2.d), 32'hFE);
    chk("b2b flags0", 32'({r.pe, r.fe}), 32'h0);
    chk("b2b flags1", 32'({r2.pe, r2.fe}), 32'h0);
    chk("b2b spacing", 32'(r2.t - r.t), 32'(FRAME));

    // Reset in the middle of DATA of frame 0x55 (after bit 3)
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(i[0] ? 1'b0 : 1'b1, CPB);
    n0 = vq.size();
    rst_n = 1'b0;
    rx_in = 1'b1;
    #1;
    chk("mid rst data_out", 32'(data_out), 32'h0);
    chk("mid rst flags", 32'({data_valid, parity_err, frame_err}), 32'h0);
    chk("mid rst busy", 32'(busy), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive_bit(1'b1, 20);
    chk("mid rst no valid", 32'(vq.size()), 32'(n0));
    send_frame(8'h99, 1'b0, 1'b1, t0);
    drive_bit(1'b1, CPB);
    chk("post rst count", 32'(vq.size()), 32'(n0 + 1));
    r = rec_at(n0);
    chk("post rst data", 32'(r.d), 32'h99);
    chk("post rst flags", 32'({r.pe, r.fe}), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
